gated_pipe_reg: RTL and testbench

GATED_PIPE_REG -- requirements
Module: gated_pipe_reg

---
 rtl/gated_pipe_pkg.sv | 13 +
 rtl/gated_reg.sv | 35 +++
 rtl/gated_pipe_reg.sv | 70 +++++++
 tb/tb_gated_pipe_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/gated_pipe_pkg.sv
// rtl/gated_pipe_pkg.sv - shared defaults and stage record for the gated pipeline register
package gated_pipe_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 1;

    // One pipeline stage as seen at the default width: payload plus its qualifier.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/gated_reg.sv
// rtl/gated_reg.sv - single clock-enabled pipeline stage with flush and synchronous reset
module gated_reg
    import gated_pipe_pkg::*;
#(
    parameter int                 WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Flush only kills the qualifier; the payload keeps moving with ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else begin
            if (ce) begin
                q <= d;
            end
            if (flush) begin
                q_valid <= 1'b0;
            end else if (ce) begin
                q_valid <= d_valid;
            end
        end
    end

endmodule

// File: rtl/gated_pipe_reg.sv
// rtl/gated_pipe_reg.sv - DEPTH-stage clock-enabled pipeline; GATED_PIPE_REG_OCC_EN adds the OCC occupancy port
module gated_pipe_reg
    import gated_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID
`ifdef GATED_PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

    // Index 0 is the module input; index k+1 is the output of stage k.
    logic [DEPTH:0][WIDTH-1:0] data_chain;
    logic [DEPTH:0]            valid_chain;

    assign data_chain[0]  = I;
    assign valid_chain[0] = I_VALID;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        gated_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (CLK),
            .reset   (RESET),
            .ce      (CE),
            .flush   (FLUSH),
            .d       (data_chain[k]),
            .d_valid (valid_chain[k]),
            .q       (data_chain[k+1]),
            .q_valid (valid_chain[k+1])
        );
    end

    assign O       = data_chain[DEPTH];
    assign O_VALID = valid_chain[DEPTH];

`ifdef GATED_PIPE_REG_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_q;

    // Tracks valid stages: one entering and one leaving on the same edge cancel out.
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            occ_q <= '0;
        end else if (CE) begin
            case ({I_VALID, O_VALID})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_gated_pipe_reg.sv
// tb/tb_gated_pipe_reg.sv - scoreboard bench driving three pipeline shapes from shared stimulus
module tb_gated_pipe_reg;

    typedef logic [8:0] ent_q_t[$];

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CE = 1'b0;
    logic       FLUSH = 1'b0;
    logic       I_VALID = 1'b0;
    logic [7:0] I = '0;

    logic [3:0] o1, o2;
    logic [7:0] o3;
    logic       ov1, ov2, ov3;
`ifdef GATED_PIPE_REG_OCC_EN
    logic [0:0] occ1;
    logic [1:0] occ2, occ3;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int step_n   = 0;

    ent_q_t q1, q2, q3;

    always #5 CLK = ~CLK;

    gated_pipe_reg #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) u_d1 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .FLUSH(FLUSH),
        .I(I[3:0]), .I_VALID(I_VALID), .O(o1), .O_VALID(ov1)
`ifdef GATED_PIPE_REG_OCC_EN
        , .OCC(occ1)
`endif
    );

    gated_pipe_reg #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'h5)) u_d2 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .FLUSH(FLUSH),
        .I(I[3:0]), .I_VALID(I_VALID), .O(o2), .O_VALID(ov2)
`ifdef GATED_PIPE_REG_OCC_EN
        , .OCC(occ2)
`endif
    );

    gated_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h03)) u_d3 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .FLUSH(FLUSH),
        .I(I), .I_VALID(I_VALID), .O(o3), .O_VALID(ov3)
`ifdef GATED_PIPE_REG_OCC_EN
        , .OCC(occ3)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry {valid, data}; element 0 is the word currently presented at O.
    function automatic ent_q_t advance(input ent_q_t q, input int depth, input logic [7:0] rv,
                                       input logic [7:0] mask, input logic rst, input logic ce,
                                       input logic fl, input logic v, input logic [7:0] din);
        ent_q_t r;
        r = q;
        if (rst) begin
            r = {};
            for (int k = 0; k < depth; k++) r.push_back({1'b0, rv});
            return r;
        end
        if (ce) begin
            void'(r.pop_front());
            r.push_back({v & ~fl, din & mask});
        end
        if (fl) begin
            foreach (r[k]) r[k][8] = 1'b0;
        end
        return r;
    endfunction

    function automatic int count_valid(input ent_q_t q);
        int c = 0;
        foreach (q[k]) c += int'(q[k][8]);
        return c;
    endfunction

    task automatic step(input logic rst, input logic ce, input logic fl, input logic v,
                        input logic [7:0] din);
        logic [8:0] e1, e2, e3;
        RESET = rst; CE = ce; FLUSH = fl; I_VALID = v; I = din;
        @(posedge CLK);
        q1 = advance(q1, 1, 8'h00, 8'h0F, rst, ce, fl, v, din);
        q2 = advance(q2, 2, 8'h05, 8'h0F, rst, ce, fl, v, din);
        q3 = advance(q3, 3, 8'h03, 8'hFF, rst, ce, fl, v, din);
        #1;
        step_n++;
        e1 = q1[0]; e2 = q2[0]; e3 = q3[0];
        check_eq($sformatf("s%0d d1.O", step_n), 32'(o1), 32'(e1[3:0]));
        check_eq($sformatf("s%0d d1.O_VALID", step_n), 32'(ov1), 32'(e1[8]));
        check_eq($sformatf("s%0d d2.O", step_n), 32'(o2), 32'(e2[3:0]));
        check_eq($sformatf("s%0d d2.O_VALID", step_n), 32'(ov2), 32'(e2[8]));
        check_eq($sformatf("s%0d d3.O", step_n), 32'(o3), 32'(e3[7:0]));
        check_eq($sformatf("s%0d d3.O_VALID", step_n), 32'(ov3), 32'(e3[8]));
`ifdef GATED_PIPE_REG_OCC_EN
        check_eq($sformatf("s%0d d1.OCC", step_n), 32'(occ1), 32'(count_valid(q1)));
        check_eq($sformatf("s%0d d2.OCC", step_n), 32'(occ2), 32'(count_valid(q2)));
        check_eq($sformatf("s%0d d3.OCC", step_n), 32'(occ3), 32'(count_valid(q3)));
`endif
    endtask

    initial begin
        // Reset wins over flush, enable and live input data.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        check_eq("reset d3.O literal", 32'(o3), 32'h03);
        check_eq("reset d2.O literal", 32'(o2), 32'h05);

        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA);
        check_eq("d1 first word", 32'(o1), 32'hA);
        check_eq("d1 first valid", 32'(ov1), 32'h1);

        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
        check_eq("d3 0x11 at third edge", 32'(o3), 32'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("d3 0x22 next", 32'(o3), 32'h22);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("d3 0x33 next", 32'(o3), 32'h33);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Word 0x05 enters, advances once, then stalls with changing inputs.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Fill, then flush with a valid word arriving, then drain.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h40 + k));
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Continuous valid traffic.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h60 + k));
        // Flush while stalled, then refill.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h70 + k));
        // Reset mid-stream discards everything in flight.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < 80; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
